rx_phase_search: RTL

Receive-side timing-phase recovery and slicer for the BPSK link. Sits after the matched RRC filter, which delivers OS samples per baud. The block measures average magnitude per sampling phase over a fixed window and selects the strongest phase. It decimates to one sample per baud at that phase and slices the sign into a bit stream for the BER checker. It is the automatic counterpart of the transmit upsampler and the fixed `offset` selector, with a manual override that keeps the existing 2-bit `offset` behaviour.

---
 rtl/rx_pkg.sv | 10 +
 rtl/rx_phase_search_if.sv | 16 +
 rtl/phase_energy_acc.sv | 48 ++++
 rtl/rx_phase_search.sv | 57 +++++
 4 files changed

// File: rtl/rx_pkg.sv
// rx_pkg: shared FSM encoding, parameter defaults and accumulator sizing for the BPSK receive path
package rx_pkg;
    typedef enum logic {SEARCH, TRACK} state_t;
    localparam int OS_DEF = 4;
    localparam int NB_DATA_DEF = 8;
    localparam int WIN_BAUDS_DEF = 1024;
    function automatic int acc_width(input int nb_data, input int win_bauds);
        return nb_data - 1 + $clog2(win_bauds);
    endfunction
endpackage

// File: rtl/rx_phase_search_if.sv
// rx_phase_search_if: sample/control inputs and sliced-bit/phase outputs of the phase searcher
interface rx_phase_search_if #(parameter int OS = 4, parameter int NB_DATA = 8);
    localparam int PW = $clog2(OS);
    logic                      enable;
    logic signed [NB_DATA-1:0] i_sample;
    logic                      i_manual;
    logic [PW-1:0]             offset;
    logic                      o_bit;
    logic                      o_bit_valid;
    logic [PW-1:0]             o_phase;
    logic                      o_locked;
    modport master (output enable, i_sample, i_manual, offset,
                    input  o_bit, o_bit_valid, o_phase, o_locked);
    modport slave  (input  enable, i_sample, i_manual, offset,
                    output o_bit, o_bit_valid, o_phase, o_locked);
endinterface

// File: rtl/phase_energy_acc.sv
// phase_energy_acc: per-phase saturated |x| accumulators and lowest-index argmax at window end
module phase_energy_acc
    import rx_pkg::*;
#(
    parameter int OS        = OS_DEF,
    parameter int NB_DATA   = NB_DATA_DEF,
    parameter int WIN_BAUDS = WIN_BAUDS_DEF
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      first,
    input  logic                      last,
    input  logic signed [NB_DATA-1:0] sample,
    input  logic [$clog2(OS)-1:0]     ph,
    output logic [$clog2(OS)-1:0]     win_idx,
    output logic                      done
);
    localparam int AW = acc_width(NB_DATA, WIN_BAUDS);
    localparam int PW = $clog2(OS);
    logic [AW-1:0]        acc [OS];
    logic [AW-1:0]        nxt [OS];
    logic [AW-1:0]        best;
    logic [NB_DATA-1:0]   neg;
    logic [NB_DATA-2:0]   mag;
    assign neg  = -sample;
    // negating the most negative value leaves the sign set; that case saturates
    assign mag  = !sample[NB_DATA-1] ? sample[NB_DATA-2:0] : neg[NB_DATA-1] ? '1 : neg[NB_DATA-2:0];
    assign done = enable & last;
    always_comb begin
        for (int i = 0; i < OS; i++)
            nxt[i] = (PW'(i) == ph) ? (first ? AW'(mag) : acc[i] + AW'(mag)) : acc[i];
        win_idx = '0;
        best    = nxt[0];
        for (int i = 1; i < OS; i++)
            if (nxt[i] > best) begin
                best    = nxt[i];
                win_idx = PW'(i);
            end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < OS; i++) acc[i] <= '0;
        end else if (enable) begin
            for (int i = 0; i < OS; i++) acc[i] <= nxt[i];
        end
    end
endmodule

// File: rtl/rx_phase_search.sv
// rx_phase_search: picks the strongest sampling phase per window, decimates to one sample per baud
// and slices the sign; manual mode forces the phase from offset.
module rx_phase_search
    import rx_pkg::*;
#(
    parameter int OS        = OS_DEF,
    parameter int NB_DATA   = NB_DATA_DEF,
    parameter int WIN_BAUDS = WIN_BAUDS_DEF
) (
    input  logic               clock,
    input  logic               reset,
    rx_phase_search_if.slave   bus
);
    localparam int PW = $clog2(OS);
    localparam int BW = $clog2(WIN_BAUDS);
    logic [PW-1:0] ph;
    logic [PW-1:0] auto_ph;
    logic [PW-1:0] win_idx;
    logic [BW-1:0] baud;
    logic          done;
    state_t        state, state_nxt;
    phase_energy_acc #(.OS(OS), .NB_DATA(NB_DATA), .WIN_BAUDS(WIN_BAUDS)) u_acc (
        .clock   (clock),
        .reset   (reset),
        .enable  (bus.enable),
        .first   (baud == '0),
        .last    ((&ph) && (&baud)),
        .sample  (bus.i_sample),
        .ph      (ph),
        .win_idx (win_idx),
        .done    (done)
    );
    always_comb begin
        state_nxt = (state == SEARCH && done) ? TRACK : state;
    end
    assign bus.o_phase  = bus.i_manual ? bus.offset : auto_ph;
    assign bus.o_locked = bus.i_manual | (state == TRACK);
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= SEARCH;
            ph              <= '0;
            baud            <= '0;
            auto_ph         <= '0;
            bus.o_bit       <= 1'b0;
            bus.o_bit_valid <= 1'b0;
        end else begin
            state           <= state_nxt;
            bus.o_bit_valid <= bus.enable && (ph == bus.o_phase);
            if (done) auto_ph <= win_idx;
            if (bus.enable) begin
                ph <= ph + 1'b1;
                if (&ph) baud <= baud + 1'b1;
                if (ph == bus.o_phase) bus.o_bit <= ~bus.i_sample[NB_DATA-1];
            end
        end
    end
endmodule
